// File: rtl/index_onehot_pkg.sv
// Shared types and helpers for the index-to-one-hot driver.
package index_onehot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } drv_state_e;

    // Widest one-hot vector the decode helper can produce.
    localparam int ONEHOT_MAX = 256;

    // Decode idx to one-hot over 'width' outputs; out-of-range yields zero.
    function automatic logic [ONEHOT_MAX-1:0] idx_to_onehot(input logic [31:0] idx,
                                                           input int unsigned width);
        logic [ONEHOT_MAX-1:0] v;
        v = '0;
        if ((idx < width) && (idx < ONEHOT_MAX))
            v[idx[7:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/index_onehot_hold_cnt.sv
// Loadable down-counter shared by the hold and gap phases; flags the last cycle.
module index_onehot_hold_cnt #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_last
);

    logic [CW-1:0] r_cnt;

    // Counts down to 1 within a phase, then parks at 0 once the phase ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_last = (r_cnt == CW'(1));

endmodule

// File: rtl/index_onehot_driver.sv
// Accepts an encoded index, drives its one-hot decode for HOLD_CYCLES,
// then an optional all-zero gap of GAP_CYCLES before the next index.
module index_onehot_driver
    import index_onehot_pkg::*;
#(
    parameter  int NUM_OUT     = 4,
    parameter  int HOLD_CYCLES = 1,
    parameter  int GAP_CYCLES  = 0,
    localparam int IDX_W       = $clog2(NUM_OUT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IDX_W-1:0]   in_idx,
    output logic [NUM_OUT-1:0] out_onehot,
    output logic               out_active,
    output logic               busy,
    output logic               err_oor
);

    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    generate
        if (NUM_OUT < 2 || NUM_OUT > ONEHOT_MAX) begin : g_bad_num_out
            $error("index_onehot_driver: NUM_OUT must be in [2, ONEHOT_MAX]");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("index_onehot_driver: HOLD_CYCLES must be >= 1");
        end
        if (GAP_CYCLES < 0) begin : g_bad_gap
            $error("index_onehot_driver: GAP_CYCLES must be >= 0");
        end
    endgenerate

    drv_state_e          r_state, w_state_nxt;
    logic [NUM_OUT-1:0]  r_onehot, w_onehot_nxt, w_dec;
    logic                r_active, r_err;
    logic                w_last, w_load, w_acc, w_oor;
    logic [CW-1:0]       w_load_val;

    index_onehot_hold_cnt #(.CW(CW)) u_hold_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_load_val(w_load_val),
        .o_last    (w_last)
    );

    // Ready depends only on registered state so upstream sees no comb loop.
    assign in_ready = (r_state == IDLE)
                    | ((r_state == DRIVE) & w_last & (GAP_CYCLES == 0))
                    | ((r_state == GAP) & w_last);

    assign w_acc = in_valid & in_ready;
    assign w_oor = (32'(in_idx) >= 32'(NUM_OUT));
    assign w_dec = NUM_OUT'(idx_to_onehot(32'(in_idx), NUM_OUT));

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = CW'(HOLD_CYCLES);
        if (w_acc) begin
            if (w_oor) begin
                w_state_nxt = IDLE;
            end else begin
                w_state_nxt = DRIVE;
                w_load      = 1'b1;
            end
        end else begin
            case (r_state)
                DRIVE: if (w_last) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = GAP;
                        w_load      = 1'b1;
                        w_load_val  = CW'(GAP_CYCLES);
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                GAP:     if (w_last) w_state_nxt = IDLE;
                default: ;
            endcase
        end
    end

    // Out-of-range accepts decode to zero, so the vector simply clears.
    always_comb begin
        w_onehot_nxt = '0;
        if (w_acc)
            w_onehot_nxt = w_dec;
        else if (r_state == DRIVE && !w_last)
            w_onehot_nxt = r_onehot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_onehot <= '0;
            r_active <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_onehot <= w_onehot_nxt;
            r_active <= |w_onehot_nxt;
            r_err    <= w_acc & w_oor;
        end
    end

    assign out_onehot = r_onehot;
    assign out_active = r_active;
    assign err_oor    = r_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_index_onehot_driver.sv
// Directed bench for index_onehot_driver across four parameter sets.
module tb_index_onehot_driver;

    logic clk, rst_n;
    int   n_tests, n_fail;

    // A: NUM_OUT=4 HOLD=3 GAP=1
    logic       a_v, a_r, a_act, a_busy, a_err;
    logic [1:0] a_i;
    logic [3:0] a_oh;
    // B: NUM_OUT=5 HOLD=1 GAP=0
    logic       b_v, b_r, b_act, b_busy, b_err;
    logic [2:0] b_i;
    logic [4:0] b_oh;
    // C: NUM_OUT=4 HOLD=4 GAP=0
    logic       c_v, c_r, c_act, c_busy, c_err;
    logic [1:0] c_i;
    logic [3:0] c_oh;
    // D: NUM_OUT=4 HOLD=1 GAP=0
    logic       d_v, d_r, d_act, d_busy, d_err;
    logic [1:0] d_i;
    logic [3:0] d_oh;

    index_onehot_driver #(.NUM_OUT(4), .HOLD_CYCLES(3), .GAP_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_v), .in_ready(a_r), .in_idx(a_i),
        .out_onehot(a_oh), .out_active(a_act), .busy(a_busy), .err_oor(a_err));
    index_onehot_driver #(.NUM_OUT(5), .HOLD_CYCLES(1), .GAP_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_v), .in_ready(b_r), .in_idx(b_i),
        .out_onehot(b_oh), .out_active(b_act), .busy(b_busy), .err_oor(b_err));
    index_onehot_driver #(.NUM_OUT(4), .HOLD_CYCLES(4), .GAP_CYCLES(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_v), .in_ready(c_r), .in_idx(c_i),
        .out_onehot(c_oh), .out_active(c_act), .busy(c_busy), .err_oor(c_err));
    index_onehot_driver #(.NUM_OUT(4), .HOLD_CYCLES(1), .GAP_CYCLES(0)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_v), .in_ready(d_r), .in_idx(d_i),
        .out_onehot(d_oh), .out_active(d_act), .busy(d_busy), .err_oor(d_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_a [1:7];
        logic [1:0] d_seq [0:3];
        logic [3:0] d_exp [0:3];
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        a_v = 0; a_i = 0; b_v = 0; b_i = 0;
        c_v = 0; c_i = 0; d_v = 0; d_i = 0;

        // 1. reset
        @(negedge clk); @(negedge clk);
        chk("rst_onehot", a_oh, 0);
        chk("rst_active", a_act, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_err", a_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", a_r, 1);
        chk("rel_busy", a_busy, 0);

        // 2. single decode idx=2
        a_v = 1; a_i = 2;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) a_v = 0;
            if (k <= 3) begin
                chk($sformatf("single_oh_k%0d", k), a_oh, 4'b0100);
                chk($sformatf("single_act_k%0d", k), a_act, 1);
                chk($sformatf("single_rdy_k%0d", k), a_r, 0);
            end else if (k == 4) begin
                chk("single_gap_oh", a_oh, 4'b0000);
                chk("single_gap_rdy", a_r, 1);
                chk("single_gap_busy", a_busy, 1);
            end else begin
                chk("single_idle_busy", a_busy, 0);
                chk("single_idle_rdy", a_r, 1);
            end
        end

        // 3. back-to-back idx=0 then idx=3, valid held high
        exp_a[1] = 4'b0001; exp_a[2] = 4'b0001; exp_a[3] = 4'b0001; exp_a[4] = 4'b0000;
        exp_a[5] = 4'b1000; exp_a[6] = 4'b1000; exp_a[7] = 4'b1000;
        a_v = 1; a_i = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) a_i = 3;
            if (k == 5) a_v = 0;
            chk($sformatf("b2b_oh_k%0d", k), a_oh, exp_a[k]);
            chk($sformatf("b2b_act_k%0d", k), a_act, (exp_a[k] != 0));
            if (k == 4) chk("b2b_gap_rdy", a_r, 1);
            if (k == 2) chk("b2b_hold_rdy", a_r, 0);
        end
        @(negedge clk);
        chk("b2b_tail_gap", a_oh, 0);
        @(negedge clk);
        chk("b2b_tail_busy", a_busy, 0);

        // 4. out of range idx=6 on NUM_OUT=5, then highest legal idx=4
        b_v = 1; b_i = 6;
        @(negedge clk);
        b_v = 0;
        chk("oor_err", b_err, 1);
        chk("oor_oh", b_oh, 0);
        chk("oor_busy", b_busy, 0);
        chk("oor_rdy", b_r, 1);
        @(negedge clk);
        chk("oor_err_clear", b_err, 0);
        b_v = 1; b_i = 4;
        @(negedge clk);
        b_v = 0;
        chk("top_idx_oh", b_oh, 5'b10000);
        chk("top_idx_err", b_err, 0);
        @(negedge clk);
        chk("top_idx_done", b_oh, 0);

        // 5. reset mid-drive on HOLD=4
        c_v = 1; c_i = 3;
        @(negedge clk);
        c_v = 0;
        chk("mid_oh_k1", c_oh, 4'b1000);
        @(negedge clk);
        chk("mid_oh_k2", c_oh, 4'b1000);
        rst_n = 1'b0;
        #1;
        chk("mid_async_oh", c_oh, 0);
        chk("mid_async_act", c_act, 0);
        chk("mid_async_busy", c_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_post_oh", c_oh, 0);
        chk("mid_post_busy", c_busy, 0);
        chk("mid_post_rdy", c_r, 1);
        c_v = 1; c_i = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) c_v = 0;
            chk($sformatf("mid_new_oh_k%0d", k), c_oh, (k <= 4) ? 4'b0010 : 4'b0000);
            if (k == 3) chk("mid_new_rdy_k3", c_r, 0);
            if (k == 4) chk("mid_new_rdy_last", c_r, 1);
        end
        chk("mid_new_busy_end", c_busy, 0);

        // 6. streaming on HOLD=1 GAP=0
        d_seq[0] = 1; d_seq[1] = 2; d_seq[2] = 3; d_seq[3] = 0;
        d_exp[0] = 4'b0010; d_exp[1] = 4'b0100; d_exp[2] = 4'b1000; d_exp[3] = 4'b0001;
        chk("stream_rdy_k0", d_r, 1);
        d_v = 1; d_i = d_seq[0];
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) d_i = d_seq[k+1];
            else d_v = 0;
            chk($sformatf("stream_oh_k%0d", k), d_oh, d_exp[k]);
            chk($sformatf("stream_rdy_k%0d", k + 1), d_r, 1);
        end
        @(negedge clk);
        chk("stream_end_oh", d_oh, 0);
        chk("stream_end_busy", d_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/index_onehot_driver.md
Name: index_onehot_driver

Overview:
Sequential counterpart of the priority encoder. It accepts an encoded index over a valid/ready handshake and decodes it to a one-hot output vector. The vector is held for a programmable number of cycles, then followed by an optional idle gap. It sits downstream of encoder and arbitration logic and drives one-hot select, enable or grant lines into datapath blocks.

Parameters:
NUM_OUT, 4, number of one-hot outputs; must be ≥2.
HOLD_CYCLES, 1, cycles the decoded vector is held; must be ≥1.
GAP_CYCLES, 0, all-zero cycles inserted after each hold; must be ≥0.
IDX_W (localparam), $clog2(NUM_OUT), index width.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_idx is valid
in_ready  output  1  block can accept an index this cycle
in_idx  input  IDX_W  encoded index to decode
out_onehot  output  NUM_OUT  decoded vector; bit in_idx set while driving
out_active  output  1  high exactly when out_onehot is non-zero
busy  output  1  state is not IDLE
err_oor  output  1  one-cycle pulse: accepted index ≥ NUM_OUT

Behaviour:
- Interface: one clock, clk. Reset is asynchronous, active-low, on rst_n. While rst_n=0: state=IDLE, counter=0, out_onehot=0, out_active=0, busy=0, err_oor=0. in_ready=1 once rst_n=1.
- States: IDLE, DRIVE, GAP. The state enum lives in the package.
- Accept: a transfer occurs on a rising edge where in_valid & in_ready. in_ready is combinational from registered state only and never depends on in_valid. It is high when any of these holds:
  - state==IDLE;
  - state==DRIVE, last hold cycle, GAP_CYCLES==0;
  - state==GAP, last gap cycle.
- Valid in-range accept at edge T: registers load. out_onehot = 1<<in_idx from cycle T+1 for exactly HOLD_CYCLES cycles. The state is DRIVE and the counter counts the hold.
- DRIVE exit:
  - GAP_CYCLES>0: go to GAP with out_onehot=0 for exactly GAP_CYCLES cycles, then IDLE.
  - GAP_CYCLES==0: go to IDLE.
  - An accept on the last DRIVE or GAP cycle goes directly to a new DRIVE with no bubble. Back-to-back throughput is therefore one index per HOLD_CYCLES+GAP_CYCLES cycles.
- Out-of-range accept (in_idx ≥ NUM_OUT, possible only when NUM_OUT is not a power of two):
  - The index is consumed.
  - err_oor=1 for cycle T+1 only.
  - out_onehot stays 0 and the state goes to IDLE.
- in_valid while in_ready=0: nothing happens. The upstream holds in_idx stable until accepted.
- out_onehot is registered, never glitches, and has at most one bit set. out_active equals the OR-reduction of out_onehot and is registered.
- Counter width is $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). It reloads on each state entry and counts down to 1; "last cycle" means counter==1.
- Reset mid-DRIVE or mid-GAP: all outputs clear immediately (asynchronously). After release the block is IDLE and does not resume the aborted operation.
- in_idx is sampled only on an accepted edge.
- Parameter legality is checked by elaboration-time assertions.

Decomposition:
- Package index_onehot_pkg holds:
  - state typedef drv_state_e {IDLE, DRIVE, GAP};
  - function idx_to_onehot(idx), parameterised by width, returning zero for out-of-range indices.
- One sub-module is natural: index_onehot_hold_cnt, the loadable down-counter with a last-cycle flag, shared by the DRIVE and GAP states.
- The FSM and output registers stay in the top module.

Test Plan:
1. Reset with NUM_OUT=4, HOLD=3, GAP=1 → during reset all outputs 0; after release in_ready=1, busy=0.
2. Single decode, NUM_OUT=4, HOLD=3, GAP=1: idx=2 accepted at T → out_onehot=4'b0100 for T+1..T+3; 4'b0000 at T+4; in_ready=1 during T+4; busy=0 at T+5.
3. Back-to-back, HOLD=3, GAP=1: in_valid held high, idx=0 then idx=3 → out_onehot 0001,0001,0001,0000,1000,1000,1000; second accept on the gap cycle.
4. Out of range, NUM_OUT=5 (IDX_W=3): idx=6 accepted at T → err_oor=1 only at T+1; out_onehot=0; busy=0; in_ready stays 1.
5. Reset mid-drive, HOLD=4: assert rst_n=0 on the 2nd hold cycle → out_onehot=0 immediately. After release: IDLE, no residual drive, next accepted idx=1 produces a normal 4-cycle 0010.
6. Streaming, HOLD=1, GAP=0: idx 1,2,3,0 on consecutive cycles → in_ready constant 1; out_onehot 0010,0100,1000,0001 on consecutive cycles.
